// File: rtl/expr_check_if.sv
// Character stream in, expression status out, for the expr_check syntax checker.
interface expr_check_if #(
  parameter int DEP_W = 2,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [7:0]       in;
  logic             out;
  logic             err;
  logic [DEP_W-1:0] depth;
  logic [CNT_W-1:0] operand_cnt;

  modport master (output in_valid, in, input out, err, depth, operand_cnt);
  modport slave  (input in_valid, in, output out, err, depth, operand_cnt);
endinterface

// File: rtl/expr_check.sv
// Streaming syntax checker for arithmetic expressions, one ASCII char per valid cycle.
// All outputs are registered and reflect the character consumed on the previous edge.
module expr_check #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 3,
  parameter int CNT_W      = 8,
  parameter int DEP_W      = 2
) (
  input logic          clk,
  input logic          clr,
  expr_check_if.slave  bus
);
  localparam int DC_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_START, S_NUM, S_AFTER, S_ERR} state_t;

  state_t           state, state_nxt;
  logic [DC_W-1:0]  dcnt, dcnt_nxt;
  logic [DEP_W-1:0] depth_q, depth_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             out_q, out_nxt;
  logic             err_q, err_nxt;

  logic is_digit, is_op, is_lp, is_rp, is_sp;
  logic depth_full, depth_zero;

  assign is_digit   = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign is_op      = (bus.in == 8'h2B) || (bus.in == 8'h2D) ||
                      (bus.in == 8'h2A) || (bus.in == 8'h2F);
  assign is_lp      = (bus.in == 8'h28);
  assign is_rp      = (bus.in == 8'h29);
  assign is_sp      = (bus.in == 8'h20);
  assign depth_full = (depth_q == DEP_W'(MAX_DEPTH));
  assign depth_zero = (depth_q == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_START;
      dcnt    <= '0;
      depth_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      dcnt    <= dcnt_nxt;
      depth_q <= depth_nxt;
      cnt_q   <= cnt_nxt;
      out_q   <= out_nxt;
      err_q   <= err_nxt;
    end
  end

  // Error transitions only move the state, so counters freeze at their last value.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    depth_nxt = depth_q;
    cnt_nxt   = cnt_q;
    out_nxt   = out_q;
    err_nxt   = err_q;
    if (bus.in_valid) begin
      case (state)
        S_START: begin
          if (is_digit) begin
            state_nxt = S_NUM;
            dcnt_nxt  = DC_W'(1);
            cnt_nxt   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          end else if (is_lp) begin
            if (depth_full) state_nxt = S_ERR;
            else            depth_nxt = depth_q + 1'b1;
          end else if (!is_sp) begin
            state_nxt = S_ERR;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            if (dcnt == DC_W'(MAX_DIGITS)) state_nxt = S_ERR;
            else                           dcnt_nxt  = dcnt + 1'b1;
          end else if (is_op) begin
            state_nxt = S_START;
          end else if (is_rp) begin
            if (depth_zero) begin
              state_nxt = S_ERR;
            end else begin
              depth_nxt = depth_q - 1'b1;
              state_nxt = S_AFTER;
            end
          end else if (is_sp) begin
            state_nxt = S_AFTER;
          end else begin
            state_nxt = S_ERR;
          end
        end
        S_AFTER: begin
          if (is_op) begin
            state_nxt = S_START;
          end else if (is_rp) begin
            if (depth_zero) state_nxt = S_ERR;
            else            depth_nxt = depth_q - 1'b1;
          end else if (!is_sp) begin
            state_nxt = S_ERR;
          end
        end
        default: ;
      endcase
      out_nxt = ((state_nxt == S_NUM) || (state_nxt == S_AFTER)) && (depth_nxt == '0);
      err_nxt = (state_nxt == S_ERR);
    end
  end

  assign bus.out         = out_q;
  assign bus.err         = err_q;
  assign bus.depth       = depth_q;
  assign bus.operand_cnt = cnt_q;
endmodule
